main_mem_arbiter: RTL

- Shares the single-port main memory between instruction fetch (IF stage) and data access (LD/ST in the MEM stage).
- Grants one requester per cycle and drives the memory port.
- Routes read data back to the owner after a fixed latency; drops fetch returns on a pipeline flush.
- Gives data access priority, with an anti-starvation boost for fetch. Sits between the pipeline controller's stall/flush logic and the main memory.

---
 rtl/mem_arb_pkg.sv | 41 ++++
 rtl/mem_tag_pipe.sv | 63 ++++++
 rtl/main_mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the main-memory arbiter and its read-tag pipe.
//   arb_state_t : arbitration mode (data priority / fetch boost)
//   owner_t     : which requester owns an in-flight read
//   tag_t       : {valid, owner} record carried alongside each memory access
//   STARVE_W    : width of the fetch starvation counter
//   flush_tag() : drops the valid bit of a fetch-owned tag when flushing
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int STARVE_W = 4;

    typedef enum logic [0:0] {
        DATA_PRI = 1'b0,
        BOOST    = 1'b1
    } arb_state_t;

    typedef enum logic [0:0] {
        OWN_DATA  = 1'b0,
        OWN_FETCH = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_DATA};

    // A pipeline flush kills fetch returns only; data returns keep flowing.
    function automatic tag_t flush_tag(input tag_t t, input logic flush);
        tag_t r;
        r = t;
        if (flush && (t.owner == OWN_FETCH)) begin
            r.valid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_tag_pipe.sv
// ---------------------------------------------------------------------------
// mem_tag_pipe
// RD_LAT-deep shift register of read tags that tracks who owns each memory
// read in flight, so the read data returning RD_LAT cycles later can be
// steered to the right requester. A flush invalidates every fetch-owned tag
// (including the one being pushed) at the clock edge, and suppresses a
// fetch return sitting at the head during the flush cycle itself.
//
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   i_push_valid  : a read is issued this cycle (writes push an invalid tag)
//   i_push_fetch  : the issued access belongs to instruction fetch
//   i_flush       : discard in-flight fetch returns
//   o_d_rvalid    : data-owned read returns this cycle
//   o_f_rvalid    : fetch-owned read returns this cycle
// ---------------------------------------------------------------------------
module mem_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT = 1   // legal range 1..4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push_valid,
    input  logic i_push_fetch,
    input  logic i_flush,
    output logic o_d_rvalid,
    output logic o_f_rvalid
);

    tag_t r_pipe [RD_LAT];
    tag_t w_push_tag;
    tag_t w_head;

    always_comb begin
        w_push_tag.valid = i_push_valid;
        w_push_tag.owner = i_push_fetch ? OWN_FETCH : OWN_DATA;
    end

    // NOTE: this tag array is control state (its valid bits create rvalid
    // pulses), so every entry is reset; a pure data RAM would not need it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe[i] <= TAG_IDLE;
            end
        end else begin
            // NOTE: non-blocking assignments let every stage sample the
            // previous stage's old value, which is what makes this a shift.
            r_pipe[0] <= flush_tag(w_push_tag, i_flush);
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= flush_tag(r_pipe[i-1], i_flush);
            end
        end
    end

    assign w_head = r_pipe[RD_LAT-1];

    assign o_d_rvalid = w_head.valid && (w_head.owner == OWN_DATA);
    // The flush edge has not yet cleared the head, so mask it here.
    assign o_f_rvalid = w_head.valid && (w_head.owner == OWN_FETCH) && !i_flush;

endmodule

// File: rtl/main_mem_arbiter.sv
// ---------------------------------------------------------------------------
// main_mem_arbiter
// Shares the single-port main memory between instruction fetch and the
// LD/ST data path. One requester is granted per cycle (combinationally);
// data has priority, but after STARVE_MAX consecutive denied fetch cycles
// the arbiter enters BOOST for one grant, giving fetch priority. Read data
// comes back RD_LAT cycles after the grant and is flagged to its owner by a
// tag pipe; f_flush discards in-flight fetch returns.
//
// Optional build macro: ARB_PERF_CNT_EN adds conflict_cnt / boost_cnt
// (32-bit, wrapping) performance counters. Arbitration is identical either way.
//
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   d_req/d_we/d_addr/d_wdata      : data request (ST when d_we=1)
//   d_gnt/d_rvalid/d_rdata         : data grant and load return
//   f_req/f_addr                   : fetch request
//   f_gnt/f_rvalid/f_rdata         : fetch grant and instruction return
//   f_flush                        : discard in-flight fetch returns
//   mem_en/mem_we/mem_addr/
//   mem_wdata/mem_rdata            : single memory port
//   boost                          : fetch priority boost active
//   conflict_cnt/boost_cnt         : perf counters (ARB_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module main_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,   // legal range 1..4
    parameter int STARVE_MAX = 3    // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              f_flush,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              boost
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]       conflict_cnt,
    output logic [31:0]       boost_cnt
`endif
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_t          r_state;
    arb_state_t          w_state_nxt;
    logic [STARVE_W-1:0] r_starve;
    logic [STARVE_W-1:0] w_starve_nxt;
    logic                w_d_gnt;
    logic                w_f_gnt;
    logic                w_rd_issue;

    // ---------------------------------------------------------------
    // Grant decision: the state only picks which side wins a conflict.
    // ---------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no
        // path leaves it unassigned and no latch is inferred.
        w_d_gnt = d_req;
        w_f_gnt = f_req && !d_req;
        if (r_state == BOOST) begin
            w_f_gnt = f_req;
            w_d_gnt = d_req && !f_req;
        end
    end

    assign d_gnt  = w_d_gnt;
    assign f_gnt  = w_f_gnt;
    assign mem_en = w_d_gnt || w_f_gnt;
    assign mem_we = w_d_gnt && d_we;

    // Memory port mux; an idle port shows all-zero address and data.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
        end else if (w_f_gnt) begin
            mem_addr  = f_addr;
        end
    end

    // ---------------------------------------------------------------
    // Fetch starvation counter and priority FSM
    // ---------------------------------------------------------------
    always_comb begin
        w_starve_nxt = r_starve;
        if (!f_req || w_f_gnt) begin
            w_starve_nxt = '0;
        end else if (r_starve != STARVE_LIM) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == DATA_PRI) begin
            if (w_starve_nxt == STARVE_LIM) begin
                w_state_nxt = BOOST;
            end
        end else begin
            // BOOST is held for a single grant (or until fetch backs off).
            if (w_f_gnt || !f_req) begin
                w_state_nxt = DATA_PRI;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= DATA_PRI;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    assign boost = (r_state == BOOST);

    // ---------------------------------------------------------------
    // Read return routing
    // ---------------------------------------------------------------
    assign w_rd_issue = w_f_gnt || (w_d_gnt && !d_we);

    mem_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_tag_pipe (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push_valid (w_rd_issue),
        .i_push_fetch (w_f_gnt),
        .i_flush      (f_flush),
        .o_d_rvalid   (d_rvalid),
        .o_f_rvalid   (f_rvalid)
    );

    // Read data is shared; the rvalid strobes say whose it is.
    assign d_rdata = mem_rdata;
    assign f_rdata = mem_rdata;

`ifdef ARB_PERF_CNT_EN
    // ---------------------------------------------------------------
    // Performance counters (wrap naturally at 2^32)
    // ---------------------------------------------------------------
    logic [31:0] r_conflict_cnt;
    logic [31:0] r_boost_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_conflict_cnt <= '0;
            r_boost_cnt    <= '0;
        end else begin
            if (d_req && f_req) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
            if ((r_state == DATA_PRI) && (w_state_nxt == BOOST)) begin
                r_boost_cnt <= r_boost_cnt + 32'd1;
            end
        end
    end

    assign conflict_cnt = r_conflict_cnt;
    assign boost_cnt    = r_boost_cnt;
`endif

endmodule
